// File: rtl/blink_pkg.sv
// rtl/blink_pkg.sv - shared types, CTRL field indices, register offsets and mask rotation for blink_core
package blink_pkg;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam int EN_BIT   = 0;
  localparam int MODE_BIT = 1;
  localparam int REP_LSB  = 8;

  localparam logic [3:0] CTRL_OFFSET    = 4'h0;
  localparam logic [3:0] PERIOD_OFFSET  = 4'h4;
  localparam logic [3:0] DUTY_OFFSET    = 4'h8;
  localparam logic [3:0] PATTERN_OFFSET = 4'hC;

  // Rotate left by one inside the low n bits; bit n-1 wraps to bit 0.
  function automatic logic [31:0] rotl_mask(input logic [31:0] m, input int unsigned n);
    logic [31:0] keep;
    keep = (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    return ((m << 1) | (m >> (n - 1))) & keep;
  endfunction

endpackage

// File: rtl/blink_period_cnt.sv
// rtl/blink_period_cnt.sv - 32-bit period counter with boundary flag
module blink_period_cnt (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic [31:0] period_i,
  output logic [31:0] cnt_o,
  output logic        boundary_o
);

  logic [31:0] cnt_q, cnt_d;

  // A zero period never produces a boundary (avoids the 0-1 wrap).
  assign boundary_o = (period_i != 32'd0) && (cnt_q == period_i - 32'd1);
  assign cnt_o      = cnt_q;

  always_comb begin
    cnt_d = cnt_q + 32'd1;
    if (clear_i || boundary_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/blink_core.sv
// rtl/blink_core.sv - LED timing engine: shadowed config, run/done FSM, registered LED drive
module blink_core
  import blink_pkg::*;
#(
  parameter int NUM_LEDS           = 4,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int REP_WIDTH          = 8
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] ctrl_reg,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] period_reg,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] duty_reg,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] pattern_reg,
  input  logic                          cfg_wr,
  output logic [NUM_LEDS-1:0]           led_out,
  output logic [C_S_AXI_DATA_WIDTH-1:0] status,
  output logic                          done
);

  localparam logic [NUM_LEDS-1:0] ALL_ON = '1;

  state_t                  state_q, state_d;
  logic                    pend_q, pend_d;
  logic [31:0]             sh_period_q, sh_period_d;
  logic [31:0]             sh_duty_q, sh_duty_d;
  logic [NUM_LEDS-1:0]     sh_pat_q, sh_pat_d;
  logic                    sh_mode_q, sh_mode_d;
  logic [REP_WIDTH-1:0]    sh_rep_q, sh_rep_d;
  logic [NUM_LEDS-1:0]     mask_q, mask_d;
  logic [15:0]             cyc_q, cyc_d;
  logic [NUM_LEDS-1:0]     led_q, led_d;
  logic                    done_q, done_d;

  logic [31:0] cnt, eff_period, m32, rot_all;
  logic [15:0] cyc_inc;
  logic        boundary, en, load_idle, load_run, load, cnt_clear, unused_ok;

  assign cnt_clear = (state_q != RUN);

  blink_period_cnt u_cnt (
    .clk_i      (ACLK),
    .rst_ni     (ARESETN),
    .clear_i    (cnt_clear),
    .period_i   (sh_period_q),
    .cnt_o      (cnt),
    .boundary_o (boundary)
  );

  assign en        = ctrl_reg[EN_BIT];
  assign load_idle = (state_q == IDLE) && pend_q;
  assign load_run  = (state_q == RUN) && boundary && (pend_q || cfg_wr);
  assign load      = load_idle || load_run;
  assign cyc_inc   = (cyc_q == 16'hFFFF) ? cyc_q : cyc_q + 16'd1;
  assign unused_ok = ^{ctrl_reg, pattern_reg, rot_all};

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q | cfg_wr;
    sh_period_d = sh_period_q;
    sh_duty_d   = sh_duty_q;
    sh_pat_d    = sh_pat_q;
    sh_mode_d   = sh_mode_q;
    sh_rep_d    = sh_rep_q;
    mask_d      = mask_q;
    cyc_d       = cyc_q;
    done_d      = 1'b0;
    led_d       = '0;
    m32         = '0;
    m32[NUM_LEDS-1:0] = mask_q;
    rot_all     = rotl_mask(m32, NUM_LEDS);

    if (load) begin
      sh_period_d = period_reg;
      sh_duty_d   = duty_reg;
      sh_pat_d    = pattern_reg[NUM_LEDS-1:0];
      sh_mode_d   = ctrl_reg[MODE_BIT];
      sh_rep_d    = ctrl_reg[REP_LSB +: REP_WIDTH];
      mask_d      = pattern_reg[NUM_LEDS-1:0];
      pend_d      = load_run ? 1'b0 : cfg_wr;
    end
    eff_period = load ? period_reg : sh_period_q;

    unique case (state_q)
      IDLE: begin
        // A write in flight defers the start until its shadow load lands.
        if (en && !cfg_wr && eff_period != 32'd0) begin
          state_d = RUN;
          cyc_d   = '0;
        end
      end
      RUN: begin
        if (!en) begin
          state_d = IDLE;
        end else if (boundary) begin
          cyc_d = cyc_inc;
          if (!load) mask_d = rot_all[NUM_LEDS-1:0];
          if (sh_rep_q != '0 && cyc_inc == 16'(sh_rep_q)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else if (eff_period == 32'd0) begin
            state_d = IDLE;
          end
        end
      end
      DONE: begin
        if (!en || cfg_wr) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_q == RUN && cnt < sh_duty_q) led_d = sh_mode_q ? mask_q : ALL_ON;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= IDLE;
      pend_q      <= 1'b0;
      sh_period_q <= '0;
      sh_duty_q   <= '0;
      sh_pat_q    <= '0;
      sh_mode_q   <= 1'b0;
      sh_rep_q    <= '0;
      mask_q      <= '0;
      cyc_q       <= '0;
      led_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      sh_period_q <= sh_period_d;
      sh_duty_q   <= sh_duty_d;
      sh_pat_q    <= sh_pat_d;
      sh_mode_q   <= sh_mode_d;
      sh_rep_q    <= sh_rep_d;
      mask_q      <= mask_d;
      cyc_q       <= cyc_d;
      led_q       <= led_d;
      done_q      <= done_d;
    end
  end

  assign led_out = led_q;
  assign done    = done_q;
  assign status  = {{(C_S_AXI_DATA_WIDTH-18){1'b0}}, state_q, cyc_q};

endmodule

// File: tb/tb_blink_core.sv
// tb/tb_blink_core.sv - directed table-driven bench for blink_core
module tb_blink_core;

  logic        ACLK;
  logic        ARESETN;
  logic [31:0] ctrl_reg, period_reg, duty_reg, pattern_reg;
  logic        cfg_wr;
  logic [3:0]  led_out;
  logic [31:0] status;
  logic        done;

  int checks   = 0;
  int failures = 0;

  blink_core #(.NUM_LEDS(4), .C_S_AXI_DATA_WIDTH(32), .REP_WIDTH(8)) dut (
    .ACLK        (ACLK),
    .ARESETN     (ARESETN),
    .ctrl_reg    (ctrl_reg),
    .period_reg  (period_reg),
    .duty_reg    (duty_reg),
    .pattern_reg (pattern_reg),
    .cfg_wr      (cfg_wr),
    .led_out     (led_out),
    .status      (status),
    .done        (done)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [31:0] ctrl;
    logic [31:0] period;
    logic [31:0] duty;
    logic [31:0] pat;
    int          k;
    logic [3:0]  led;
    logic [31:0] st;
    logic [31:0] st_mask;
    logic        dn;
  } vec_t;

  vec_t vecs[19];

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic go_idle();
    ctrl_reg = 32'h0;
    cfg_wr   = 1'b0;
    repeat (3) tick();
  endtask

  task automatic write_cfg(input logic [31:0] c, input logic [31:0] p,
                           input logic [31:0] d, input logic [31:0] pt);
    ctrl_reg    = c;
    period_reg  = p;
    duty_reg    = d;
    pattern_reg = pt;
    cfg_wr      = 1'b1;
    tick();
    cfg_wr      = 1'b0;
  endtask

  initial begin
    int dn_cnt;

    // k = cycles after the write; led(k) = on(cnt=(k-2) mod P), cycles_done(k) = (k-1)/P
    vecs[0]  = '{32'h1,   32'd10, 32'd3,  32'h0, 2,  4'hF, 32'h0001_0000, 32'hFFFF_FFFF, 1'b0};
    vecs[1]  = '{32'h1,   32'd10, 32'd3,  32'h0, 4,  4'hF, 32'h0001_0000, 32'hFFFF_FFFF, 1'b0};
    vecs[2]  = '{32'h1,   32'd10, 32'd3,  32'h0, 5,  4'h0, 32'h0001_0000, 32'hFFFF_FFFF, 1'b0};
    vecs[3]  = '{32'h1,   32'd10, 32'd3,  32'h0, 11, 4'h0, 32'h0001_0001, 32'hFFFF_FFFF, 1'b0};
    vecs[4]  = '{32'h1,   32'd10, 32'd3,  32'h0, 12, 4'hF, 32'h0001_0001, 32'hFFFF_FFFF, 1'b0};
    vecs[5]  = '{32'h1,   32'd10, 32'd3,  32'h0, 25, 4'h0, 32'h0001_0002, 32'hFFFF_FFFF, 1'b0};
    vecs[6]  = '{32'h3,   32'd4,  32'd4,  32'h1, 2,  4'h1, 32'h0001_0000, 32'hFFFF_FFFF, 1'b0};
    vecs[7]  = '{32'h3,   32'd4,  32'd4,  32'h1, 6,  4'h2, 32'h0001_0001, 32'hFFFF_FFFF, 1'b0};
    vecs[8]  = '{32'h3,   32'd4,  32'd4,  32'h1, 14, 4'h8, 32'h0001_0003, 32'hFFFF_FFFF, 1'b0};
    vecs[9]  = '{32'h3,   32'd4,  32'd4,  32'h1, 18, 4'h1, 32'h0001_0004, 32'hFFFF_FFFF, 1'b0};
    vecs[10] = '{32'h3,   32'd4,  32'd4,  32'h9, 6,  4'h3, 32'h0001_0001, 32'hFFFF_FFFF, 1'b0};
    vecs[11] = '{32'h1,   32'd10, 32'd0,  32'h0, 2,  4'h0, 32'h0001_0000, 32'hFFFF_FFFF, 1'b0};
    vecs[12] = '{32'h1,   32'd10, 32'd0,  32'h0, 7,  4'h0, 32'h0001_0000, 32'hFFFF_FFFF, 1'b0};
    vecs[13] = '{32'h1,   32'd10, 32'd20, 32'h0, 11, 4'hF, 32'h0001_0001, 32'hFFFF_FFFF, 1'b0};
    vecs[14] = '{32'h1,   32'd0,  32'd3,  32'h0, 5,  4'h0, 32'h0000_0000, 32'hFFFF_0000, 1'b0};
    vecs[15] = '{32'h301, 32'd5,  32'd2,  32'h0, 12, 4'hF, 32'h0001_0002, 32'hFFFF_FFFF, 1'b0};
    vecs[16] = '{32'h301, 32'd5,  32'd2,  32'h0, 15, 4'h0, 32'h0001_0002, 32'hFFFF_FFFF, 1'b0};
    vecs[17] = '{32'h301, 32'd5,  32'd2,  32'h0, 16, 4'h0, 32'h0002_0003, 32'hFFFF_FFFF, 1'b1};
    vecs[18] = '{32'h301, 32'd5,  32'd2,  32'h0, 17, 4'h0, 32'h0002_0003, 32'hFFFF_FFFF, 1'b0};

    // Reset held 200 ns while inputs toggle
    ARESETN = 1'b0;
    ctrl_reg = '0; period_reg = '0; duty_reg = '0; pattern_reg = '0; cfg_wr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ctrl_reg    = $urandom;
      period_reg  = $urandom_range(1, 8);
      duty_reg    = $urandom_range(0, 8);
      pattern_reg = $urandom;
      cfg_wr      = 1'($urandom_range(0, 1));
      @(negedge ACLK);
      check("rst_led", {28'h0, led_out}, 32'h0);
      check("rst_status", status, 32'h0);
      check("rst_done", {31'h0, done}, 32'h0);
    end
    ctrl_reg = '0; period_reg = '0; duty_reg = '0; pattern_reg = '0; cfg_wr = 1'b0;
    @(negedge ACLK);
    ARESETN = 1'b1;
    tick();

    for (int i = 0; i < 19; i++) begin
      go_idle();
      write_cfg(vecs[i].ctrl, vecs[i].period, vecs[i].duty, vecs[i].pat);
      repeat (vecs[i].k) tick();
      check($sformatf("vec%0d_led", i), {28'h0, led_out}, {28'h0, vecs[i].led});
      check($sformatf("vec%0d_status", i), status & vecs[i].st_mask, vecs[i].st);
      check($sformatf("vec%0d_done", i), {31'h0, done}, {31'h0, vecs[i].dn});
    end

    // Finite repeat: exactly one done pulse, then restart by a write while enabled
    go_idle();
    write_cfg(32'h301, 32'd5, 32'd2, 32'h0);
    dn_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done) dn_cnt++;
    end
    check("rep_done_pulses", dn_cnt, 32'd1);
    check("rep_final_status", status, 32'h0002_0003);
    check("rep_final_led", {28'h0, led_out}, 32'h0);
    cfg_wr = 1'b1;
    tick();
    cfg_wr = 1'b0;
    check("restart_idle", status, 32'h0000_0003);
    tick();
    check("restart_run", status, 32'h0001_0000);

    // Mid-period period change: current period keeps 10 cycles, next lasts 6
    go_idle();
    write_cfg(32'h1, 32'd10, 32'd3, 32'h0);
    repeat (5) tick();
    period_reg = 32'd6;
    cfg_wr     = 1'b1;
    tick();
    cfg_wr     = 1'b0;
    repeat (4) tick();
    check("mid_k10", status, 32'h0001_0000);
    tick();
    check("mid_k11", status, 32'h0001_0001);
    repeat (5) tick();
    check("mid_k16", status, 32'h0001_0001);
    tick();
    check("mid_k17", status, 32'h0001_0002);
    repeat (6) tick();
    check("mid_k23", status, 32'h0001_0003);

    // Enable dropped mid-period
    go_idle();
    write_cfg(32'h1, 32'd10, 32'd3, 32'h0);
    repeat (3) tick();
    ctrl_reg = 32'h0;
    tick();
    check("dis_state", {30'h0, status[17:16]}, 32'h0);
    check("dis_led_hold", {28'h0, led_out}, 32'hF);
    tick();
    check("dis_led_off", {28'h0, led_out}, 32'h0);

    // Asynchronous reset mid-run clears outputs without a clock edge
    go_idle();
    write_cfg(32'h1, 32'd10, 32'd3, 32'h0);
    repeat (2) tick();
    check("pre_rst_led", {28'h0, led_out}, 32'hF);
    #2;
    ARESETN = 1'b0;
    #1;
    check("async_rst_led", {28'h0, led_out}, 32'h0);
    check("async_rst_status", status, 32'h0);
    check("async_rst_done", {31'h0, done}, 32'h0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/blink_core.md
Name: blink_core

Overview:
- Timing engine behind the Blink AXI4-Lite register slave. It sits directly downstream of the four 32-bit slave registers (slv_reg0..3 at offsets 0x0, 0x4, 0x8, 0xC).
- Turns the CTRL, PERIOD, DUTY and PATTERN values into LED waveforms with a period counter and a small FSM.
- Returns a STATUS word to the slave's read mux.

Parameters:
- NUM_LEDS, 4, LED outputs; range 1..32.
- C_S_AXI_DATA_WIDTH, 32, register width; fixed at 32.
- REP_WIDTH, 8, width of the repeat-count field in CTRL.

Ports:
- ACLK, in, 1, sole clock.
- ARESETN, in, 1, asynchronous active-low reset.
- ctrl_reg, in, 32, CTRL register (offset 0x0):
  - bit0 = enable.
  - bit1 = mode: 0 = all LEDs in unison, 1 = rotating pattern.
  - bits[15:8] = repeat count; 0 = infinite.
- period_reg, in, 32, period in ACLK cycles (offset 0x4).
- duty_reg, in, 32, on-time in ACLK cycles (offset 0x8).
- pattern_reg, in, 32, LED mask; bits[NUM_LEDS-1:0] used (offset 0xC).
- cfg_wr, in, 1, one-cycle pulse from the slave on any accepted register write.
- led_out, out, NUM_LEDS, LED drive, registered.
- status, out, 32, read-back word:
  - {14'b0, state[1:0], cycles_done[15:0]}.
- done, out, 1, one-cycle pulse when a finite repeat sequence completes.

Behaviour:
- Reset (ARESETN low, async assert, sync deassert at the ACLK edge):
  - led_out = 0, done = 0, status = 0.
  - State = IDLE, cnt = 0, cycles_done = 0.
  - Shadow registers cleared.
- Shadowing:
  - On cfg_wr, a pending flag is set.
  - Shadows (sh_period, sh_duty, sh_pat, sh_mode, sh_rep) load from the inputs in either of two cases:
    - in IDLE, on the cycle after cfg_wr;
    - at a period boundary (cnt == sh_period-1) while running.
  - Loading clears the pending flag.
  - Mid-period writes never distort the current period.
- Enable is sampled live from ctrl_reg bit0 every cycle; it is not shadowed.
- FSM states are IDLE = 0, RUN = 1, DONE = 2.
- IDLE:
  - led_out = 0.
  - Go to RUN when enable = 1 and sh_period != 0 after any pending load.
  - Entering RUN sets cnt = 0 and cycles_done = 0.
- RUN:
  - cnt increments each cycle and wraps from sh_period-1 to 0.
  - Period boundary = cycle with cnt == sh_period-1.
  - Each boundary increments cycles_done; it saturates at 0xFFFF.
- On phase:
  - Condition: cnt < sh_duty.
  - sh_duty >= sh_period gives LEDs constantly on.
  - sh_duty == 0 gives LEDs constantly off.
- led_out value, registered, one cycle after the cnt that produced it:
  - Mode 0: on = all ones, off = 0.
  - Mode 1: on = rotating mask, off = 0.
- Rotating mask:
  - Rotates left by 1 within NUM_LEDS at every boundary; bit NUM_LEDS-1 wraps to bit 0.
  - Reloads from sh_pat whenever shadows load.
- Leaving RUN:
  - enable = 0: go to IDLE the next cycle, aborting mid-period; led_out goes to 0 one cycle later.
  - sh_period becomes 0 after a boundary load: go to IDLE.
- Finite repeat (sh_rep != 0):
  - At the boundary where cycles_done reaches sh_rep: go to DONE and pulse done for exactly one cycle.
- DONE:
  - led_out = 0 and cycles_done holds.
  - Go to IDLE when enable = 0.
  - A cfg_wr while enable stays 1 also restarts: go to IDLE, load the shadows, then go to RUN.
- Simultaneous cfg_wr and boundary: the new values load at that boundary.
- Widths: cnt is 32 bits. Comparisons are unsigned and full width.
- Reset asserted mid-operation forces every output and all state to the reset values immediately.

Decomposition:
- Package blink_pkg:
  - typedef enum logic [1:0] state_t {IDLE, RUN, DONE};
  - CTRL bit and field index localparams: EN_BIT = 0, MODE_BIT = 1, REP_LSB = 8.
  - Register offset constants: 0x0, 0x4, 0x8, 0xC.
  - Function rotl_mask.
- One sub-module, blink_period_cnt:
  - Holds the 32-bit counter.
  - Inputs: clear, period.
  - Outputs: cnt, boundary.
- The FSM, shadows and LED drive stay in blink_core.

Test Plan:
- Reset/defaults: hold ARESETN low 200 ns while toggling the inputs -> led_out = 0, status = 0, done = 0 throughout.
- Unison blink: period = 10, duty = 3, mode 0, rep 0, enable = 1 -> led_out = 0xF for 3 cycles then 0x0 for 7 cycles, repeating; status[15:0] increments every 10 cycles.
- Rotating pattern: period = 4, duty = 4, mode 1, pattern = 0x1 -> led_out steps 0x1, 0x2, 0x4, 0x8, 0x1, one step per 4 cycles.
- Finite repeat: period = 5, duty = 2, rep = 3 -> exactly 3 periods, then a single-cycle done pulse; status = 0x0002_0003; led_out = 0.
- Mid-period update: while period = 10, write period = 6 at cnt = 4 -> the current period completes at 10 cycles and the next period lasts 6 cycles.
- Edge cases:
  - duty = 0 -> led_out stays 0.
  - duty = 20 with period = 10 -> led_out stays all ones.
  - period = 0 with enable = 1 -> state stays IDLE.
  - Deasserting enable mid-period -> IDLE next cycle, led_out = 0 one cycle later.
